// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, handshake constants and counter sizing for the iterative divider
package div_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} div_state_e;
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP = 1'b0;
    localparam logic RESULT_READY = 1'b1;
    localparam logic RESULT_NOT_READY = 1'b0;
    function automatic int cnt_width(input int width, input int unroll);
        return $clog2(width / unroll + 1);
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational non-restoring iteration on the signed partial remainder
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);
    logic [WIDTH:0] shifted;
    assign shifted = {rem_i[WIDTH-1:0], shift_i};
    // Intermediate wrap is harmless: the true result always lies in [-dvs, dvs)
    assign rem_o = rem_i[WIDTH] ? shifted + {1'b0, dvs_i} : shifted - {1'b0, dvs_i};
    assign q_o = ~rem_o[WIDTH];
endmodule

// File: rtl/div_iter_param.sv
// div_iter_param: multi-cycle signed/unsigned divider, UNROLL quotient bits per cycle, start/ready hold handshake
module div_iter_param
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int UNROLL = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               cancel_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               div_zero_o,
    output logic               busy_o
);
    localparam int CW = cnt_width(WIDTH, UNROLL);
    localparam logic [CW-1:0] LAST = CW'(WIDTH / UNROLL - 1);

    div_state_e         state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH:0]   pr_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               neg_quo_q, neg_rem_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q, div_zero_q;

    logic               sign1_d, sign2_d;
    logic [WIDTH-1:0]   op1_abs_d, op2_abs_d, rem_pos_d, rem_fix_d, quo_fix_d;
    logic [2*WIDTH:0]   chain [UNROLL+1];

    assign sign1_d = signed_div_i & opdata1_i[WIDTH-1];
    assign sign2_d = signed_div_i & opdata2_i[WIDTH-1];
    assign op1_abs_d = sign1_d ? -opdata1_i : opdata1_i;
    assign op2_abs_d = sign2_d ? -opdata2_i : opdata2_i;

    assign chain[0] = pr_q;
    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        logic [WIDTH:0] rem;
        logic           q;
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_i  (chain[i][2*WIDTH:WIDTH]),
            .shift_i(chain[i][WIDTH-1]),
            .dvs_i  (dvs_q),
            .rem_o  (rem),
            .q_o    (q)
        );
        assign chain[i+1] = {rem, chain[i][WIDTH-2:0], q};
    end

    assign rem_pos_d = pr_q[2*WIDTH] ? pr_q[2*WIDTH-1:WIDTH] + dvs_q : pr_q[2*WIDTH-1:WIDTH];
    assign rem_fix_d = neg_rem_q ? -rem_pos_d : rem_pos_d;
    assign quo_fix_d = neg_quo_q ? -pr_q[WIDTH-1:0] : pr_q[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            pr_q <= '0;
            dvs_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q <= '0;
            ready_q <= RESULT_NOT_READY;
            div_zero_q <= 1'b0;
        end else if (cancel_i && state_q != IDLE) begin
            state_q <= IDLE;
            result_q <= '0;
            ready_q <= RESULT_NOT_READY;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i == DIV_START && !cancel_i) begin
                        if (opdata2_i == '0) begin
                            state_q <= DONE;
                            result_q <= '0;
                            ready_q <= RESULT_READY;
                            div_zero_q <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                            cnt_q <= '0;
                            pr_q <= {{(WIDTH + 1){1'b0}}, op1_abs_d};
                            dvs_q <= op2_abs_d;
                            neg_quo_q <= sign1_d ^ sign2_d;
                            neg_rem_q <= sign1_d;
                        end
                    end
                end
                BUSY: begin
                    pr_q <= chain[UNROLL];
                    cnt_q <= cnt_q + CW'(1);
                    state_q <= (cnt_q == LAST) ? FIXUP : BUSY;
                end
                FIXUP: begin
                    state_q <= DONE;
                    result_q <= {rem_fix_d, quo_fix_d};
                    ready_q <= RESULT_READY;
                    div_zero_q <= 1'b0;
                end
                DONE: begin
                    if (start_i == DIV_STOP) begin
                        state_q <= IDLE;
                        result_q <= '0;
                        ready_q <= RESULT_NOT_READY;
                        div_zero_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o = ready_q;
    assign div_zero_o = div_zero_q;
    assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_div_iter_param.sv
// tb_div_iter_param: directed and randomised checks of 32/1 and 32/2 dividers sharing one stimulus stream
module tb_div_iter_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [63:0] res1, res2;
    logic        rdy1, rdy2, dz1, dz2, bsy1, bsy2;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    div_iter_param #(.WIDTH(32), .UNROLL(1)) u1 (
        .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .cancel_i(cancel), .result_o(res1), .ready_o(rdy1), .div_zero_o(dz1), .busy_o(bsy1)
    );
    div_iter_param #(.WIDTH(32), .UNROLL(2)) u2 (
        .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .cancel_i(cancel), .result_o(res2), .ready_o(rdy2), .div_zero_o(dz2), .busy_o(bsy2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        x = sg ? longint'($signed(a)) : longint'({32'd0, a});
        y = sg ? longint'($signed(b)) : longint'({32'd0, b});
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Next posedge is the accept edge; start is already high with operands applied
    task automatic measure(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int l1, l2;
        exp = model(sg, a, b);
        l1 = -1;
        l2 = -1;
        @(posedge clk);
        #1;
        op1 = ~a;
        op2 = b + 32'd3;
        signed_div = ~sg;
        for (int n = 1; n <= 60 && (l1 < 0 || l2 < 0); n++) begin
            @(posedge clk);
            #1;
            if (l1 < 0 && rdy1) l1 = n;
            if (l2 < 0 && rdy2) l2 = n;
        end
        check({tag, " lat1"}, 64'(l1), (b == 32'd0) ? 64'd1 : 64'd33);
        check({tag, " lat2"}, 64'(l2), (b == 32'd0) ? 64'd1 : 64'd17);
        check({tag, " res1"}, res1, exp);
        check({tag, " res2"}, res2, exp);
        check({tag, " dz1"}, 64'(dz1), 64'(b == 32'd0));
        check({tag, " dz2"}, 64'(dz2), 64'(b == 32'd0));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " drop"}, {res1, 60'd0, rdy1, dz1, rdy2, dz2}, 64'd0);
        check({tag, " drop res2"}, res2, 64'd0);
    endtask

    task automatic run(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div = sg;
        op1 = a;
        op2 = b;
        start = 1'b1;
        measure(tag, sg, a, b);
    endtask

    initial begin
        logic saw;
        repeat (2) @(posedge clk);
        #1;
        check("reset outs", {60'd0, rdy1, dz1, bsy1, bsy2}, 64'd0);
        check("reset res", res1 | res2, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run("u100/7", 1'b0, 32'd100, 32'd7);
        run("s-7/2", 1'b1, -32'sd7, 32'd2);
        run("sMIN/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run("uMAX/1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run("s-1/1", 1'b1, 32'hFFFF_FFFF, 32'd1);
        run("s-100/-7", 1'b1, -32'sd100, -32'sd7);
        run("s7/-2", 1'b1, 32'd7, -32'sd2);
        run("uMAX/MAX", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("u3/9", 1'b0, 32'd3, 32'd9);
        run("div0", 1'b0, 32'h1234, 32'd0);

        // cancel on BUSY cycle 10, then back-to-back request with start still high
        saw = 1'b0;
        @(negedge clk);
        signed_div = 1'b0;
        op1 = 32'd1000;
        op2 = 32'd3;
        start = 1'b1;
        @(posedge clk);
        repeat (9) begin
            @(posedge clk);
            #1;
            saw = saw | rdy1 | rdy2;
        end
        check("busy before cancel", {62'd0, bsy1, bsy2}, 64'd3);
        @(negedge clk);
        cancel = 1'b1;
        op1 = 32'd50;
        op2 = 32'd5;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        signed_div = 1'b1;
        check("cancel busy", {60'd0, bsy1, bsy2, rdy1, rdy2}, 64'd0);
        check("cancel no ready", 64'(saw), 64'd0);
        measure("s50/5", 1'b1, 32'd50, 32'd5);

        // cancel together with start in IDLE is not an accept
        @(negedge clk);
        start = 1'b1;
        cancel = 1'b1;
        op1 = 32'd9;
        op2 = 32'd2;
        @(posedge clk);
        #1;
        check("cancel blocks", {62'd0, bsy1, bsy2}, 64'd0);
        cancel = 1'b0;
        signed_div = 1'b0;
        measure("u9/2", 1'b0, 32'd9, 32'd2);

        // reset mid-BUSY
        @(negedge clk);
        signed_div = 1'b0;
        op1 = 32'd77;
        op2 = 32'd4;
        start = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("busy pre-rst", {62'd0, bsy1, bsy2}, 64'd3);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst mid-busy", {58'd0, bsy1, bsy2, rdy1, rdy2, dz1, dz2}, 64'd0);
        check("rst res", res1 | res2, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 24; k++) begin
            logic [31:0] a, b;
            logic sg;
            a = $urandom;
            b = (k % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            sg = k[0];
            run($sformatf("rnd%0d", k), sg, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
